// File: rtl/rename_map_table.sv
// Two-wide register rename stage: a speculative map table for renaming, and an
// architectural map table, updated by commit, that restores it on flush.
module rename_map_table #(
  parameter int ARCH_REGS      = 32,
  parameter int LOG_ARCH_REGS  = 5,
  parameter int PREG_IDX_WIDTH = 6,
  parameter int AVAIL_WIDTH    = 6
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in0_valid,
  input  logic [LOG_ARCH_REGS-1:0]  in0_rs1,
  input  logic [LOG_ARCH_REGS-1:0]  in0_rs2,
  input  logic [LOG_ARCH_REGS-1:0]  in0_rd,
  input  logic                      in0_rd_wen,
  input  logic                      in1_valid,
  input  logic [LOG_ARCH_REGS-1:0]  in1_rs1,
  input  logic [LOG_ARCH_REGS-1:0]  in1_rs2,
  input  logic [LOG_ARCH_REGS-1:0]  in1_rd,
  input  logic                      in1_rd_wen,
  output logic                      in_ready,
  input  logic [AVAIL_WIDTH-1:0]    fl_avail_count,
  output logic                      fl_req0_valid,
  output logic                      fl_req1_valid,
  input  logic [PREG_IDX_WIDTH-1:0] fl_req0_data,
  input  logic [PREG_IDX_WIDTH-1:0] fl_req1_data,
  output logic                      out0_valid,
  output logic [PREG_IDX_WIDTH-1:0] out0_prs1,
  output logic [PREG_IDX_WIDTH-1:0] out0_prs2,
  output logic [PREG_IDX_WIDTH-1:0] out0_prd,
  output logic [PREG_IDX_WIDTH-1:0] out0_old_prd,
  output logic                      out0_rd_wen,
  output logic                      out1_valid,
  output logic [PREG_IDX_WIDTH-1:0] out1_prs1,
  output logic [PREG_IDX_WIDTH-1:0] out1_prs2,
  output logic [PREG_IDX_WIDTH-1:0] out1_prd,
  output logic [PREG_IDX_WIDTH-1:0] out1_old_prd,
  output logic                      out1_rd_wen,
  input  logic                      out_ready,
  input  logic                      cmt0_valid,
  input  logic [LOG_ARCH_REGS-1:0]  cmt0_rd,
  input  logic [PREG_IDX_WIDTH-1:0] cmt0_prd,
  input  logic                      cmt1_valid,
  input  logic [LOG_ARCH_REGS-1:0]  cmt1_rd,
  input  logic [PREG_IDX_WIDTH-1:0] cmt1_prd,
  input  logic                      flush
);

  logic [PREG_IDX_WIDTH-1:0] spec_map  [ARCH_REGS];
  logic [PREG_IDX_WIDTH-1:0] arch_map  [ARCH_REGS];
  logic [PREG_IDX_WIDTH-1:0] arch_next [ARCH_REGS];

  logic                      need0, need1;
  logic [1:0]                nalloc;
  logic                      out_free, fire;
  logic [PREG_IDX_WIDTH-1:0] newp0, newp1;
  logic [PREG_IDX_WIDTH-1:0] r0_prs1, r0_prs2, r0_old;
  logic [PREG_IDX_WIDTH-1:0] r1_prs1, r1_prs2, r1_old;

  assign need0    = in0_valid & in0_rd_wen & (in0_rd != '0);
  assign need1    = in1_valid & in1_rd_wen & (in1_rd != '0);
  assign nalloc   = {1'b0, need0} + {1'b0, need1};
  assign out_free = (!out0_valid && !out1_valid) || out_ready;
  assign in_ready = !reset && out_free && !flush && (fl_avail_count >= AVAIL_WIDTH'(nalloc));
  assign fire     = in_ready & (in0_valid | in1_valid);

  // The first allocating slot always takes the freelist head.
  assign fl_req0_valid = fire & (need0 | need1);
  assign fl_req1_valid = fire & need0 & need1;
  assign newp0         = fl_req0_data;
  assign newp1         = need0 ? fl_req1_data : fl_req0_data;

  // Slot 1 sees slot 0's new mapping as if the pair were renamed in order.
  always_comb begin
    r0_prs1 = spec_map[in0_rs1];
    r0_prs2 = spec_map[in0_rs2];
    r0_old  = spec_map[in0_rd];
    r1_prs1 = (need0 && (in1_rs1 == in0_rd)) ? newp0 : spec_map[in1_rs1];
    r1_prs2 = (need0 && (in1_rs2 == in0_rd)) ? newp0 : spec_map[in1_rs2];
    r1_old  = (need0 && (in1_rd  == in0_rd)) ? newp0 : spec_map[in1_rd];
  end

  always_comb begin
    arch_next = arch_map;
    if (cmt0_valid && (cmt0_rd != '0)) arch_next[cmt0_rd] = cmt0_prd;
    if (cmt1_valid && (cmt1_rd != '0)) arch_next[cmt1_rd] = cmt1_prd;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < ARCH_REGS; i++) begin
        spec_map[i] <= PREG_IDX_WIDTH'(ARCH_REGS) + PREG_IDX_WIDTH'(i);
        arch_map[i] <= PREG_IDX_WIDTH'(ARCH_REGS) + PREG_IDX_WIDTH'(i);
      end
    end else begin
      arch_map <= arch_next;
      if (flush) begin
        spec_map <= arch_next;
      end else if (fire) begin
        if (need0) spec_map[in0_rd] <= newp0;
        if (need1) spec_map[in1_rd] <= newp1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out0_valid   <= 1'b0;
      out0_prs1    <= '0;
      out0_prs2    <= '0;
      out0_prd     <= '0;
      out0_old_prd <= '0;
      out0_rd_wen  <= 1'b0;
      out1_valid   <= 1'b0;
      out1_prs1    <= '0;
      out1_prs2    <= '0;
      out1_prd     <= '0;
      out1_old_prd <= '0;
      out1_rd_wen  <= 1'b0;
    end else if (flush) begin
      out0_valid <= 1'b0;
      out1_valid <= 1'b0;
    end else if (fire) begin
      out0_valid   <= in0_valid;
      out0_prs1    <= r0_prs1;
      out0_prs2    <= r0_prs2;
      out0_prd     <= need0 ? newp0 : '0;
      out0_old_prd <= r0_old;
      out0_rd_wen  <= need0;
      out1_valid   <= in1_valid;
      out1_prs1    <= r1_prs1;
      out1_prs2    <= r1_prs2;
      out1_prd     <= need1 ? newp1 : '0;
      out1_old_prd <= r1_old;
      out1_rd_wen  <= need1;
    end else if (out_ready) begin
      out0_valid <= 1'b0;
      out1_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rename_map_table.sv
// Bench for rename_map_table: directed scenarios with literal expectations, then
// random traffic checked every cycle against an in-order renaming model.
module tb_rename_map_table;

  logic       clock = 1'b0;
  logic       reset;
  logic       in0_valid, in0_rd_wen, in1_valid, in1_rd_wen;
  logic [4:0] in0_rs1, in0_rs2, in0_rd, in1_rs1, in1_rs2, in1_rd;
  logic       in_ready;
  logic [5:0] fl_avail_count, fl_req0_data, fl_req1_data;
  logic       fl_req0_valid, fl_req1_valid;
  logic       out0_valid, out0_rd_wen, out1_valid, out1_rd_wen;
  logic [5:0] out0_prs1, out0_prs2, out0_prd, out0_old_prd;
  logic [5:0] out1_prs1, out1_prs2, out1_prd, out1_old_prd;
  logic       out_ready;
  logic       cmt0_valid, cmt1_valid;
  logic [4:0] cmt0_rd, cmt1_rd;
  logic [5:0] cmt0_prd, cmt1_prd;
  logic       flush;

  int n_checks = 0;
  int n_fail   = 0;

  rename_map_table #(
    .ARCH_REGS(32), .LOG_ARCH_REGS(5), .PREG_IDX_WIDTH(6), .AVAIL_WIDTH(6)
  ) dut (
    .clock(clock), .reset(reset),
    .in0_valid(in0_valid), .in0_rs1(in0_rs1), .in0_rs2(in0_rs2), .in0_rd(in0_rd), .in0_rd_wen(in0_rd_wen),
    .in1_valid(in1_valid), .in1_rs1(in1_rs1), .in1_rs2(in1_rs2), .in1_rd(in1_rd), .in1_rd_wen(in1_rd_wen),
    .in_ready(in_ready), .fl_avail_count(fl_avail_count),
    .fl_req0_valid(fl_req0_valid), .fl_req1_valid(fl_req1_valid),
    .fl_req0_data(fl_req0_data), .fl_req1_data(fl_req1_data),
    .out0_valid(out0_valid), .out0_prs1(out0_prs1), .out0_prs2(out0_prs2), .out0_prd(out0_prd),
    .out0_old_prd(out0_old_prd), .out0_rd_wen(out0_rd_wen),
    .out1_valid(out1_valid), .out1_prs1(out1_prs1), .out1_prs2(out1_prs2), .out1_prd(out1_prd),
    .out1_old_prd(out1_old_prd), .out1_rd_wen(out1_rd_wen),
    .out_ready(out_ready),
    .cmt0_valid(cmt0_valid), .cmt0_rd(cmt0_rd), .cmt0_prd(cmt0_prd),
    .cmt1_valid(cmt1_valid), .cmt1_rd(cmt1_rd), .cmt1_prd(cmt1_prd),
    .flush(flush)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: map tables as plain arrays, slots renamed strictly in order.
  bit model_ok = 1'b0;
  int m_spec[32], m_arch[32];
  int m_valid[2], m_prs1[2], m_prs2[2], m_prd[2], m_old[2], m_wen[2];

  function automatic bit m_need(input int s);
    if (s == 0) return in0_valid && in0_rd_wen && (in0_rd != 0);
    return in1_valid && in1_rd_wen && (in1_rd != 0);
  endfunction

  function automatic bit m_in_ready();
    int n;
    n = int'(m_need(0)) + int'(m_need(1));
    return !reset && !flush && ((m_valid[0] == 0 && m_valid[1] == 0) || out_ready)
           && (int'(fl_avail_count) >= n);
  endfunction

  always @(posedge clock) begin : model
    int na[32], ns[32], pool[2], rs1[2], rs2[2], rd[2], vl[2];
    int p1[2], p2[2], pd[2], op[2], wn[2];
    int k;
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        na[i] = 32 + i;
      end
      m_spec  <= na;
      m_arch  <= na;
      m_valid <= '{0, 0}; m_prs1 <= '{0, 0}; m_prs2 <= '{0, 0};
      m_prd   <= '{0, 0}; m_old  <= '{0, 0}; m_wen  <= '{0, 0};
      model_ok <= 1'b1;
    end else begin
      na = m_arch;
      if (cmt0_valid && cmt0_rd != 0) na[cmt0_rd] = cmt0_prd;
      if (cmt1_valid && cmt1_rd != 0) na[cmt1_rd] = cmt1_prd;
      m_arch <= na;
      if (flush) begin
        m_spec  <= na;
        m_valid <= '{0, 0};
      end else if (m_in_ready() && (in0_valid || in1_valid)) begin
        ns = m_spec;
        pool[0] = fl_req0_data; pool[1] = fl_req1_data;
        rs1[0] = in0_rs1; rs2[0] = in0_rs2; rd[0] = in0_rd; vl[0] = in0_valid;
        rs1[1] = in1_rs1; rs2[1] = in1_rs2; rd[1] = in1_rd; vl[1] = in1_valid;
        k = 0;
        for (int s = 0; s < 2; s++) begin
          p1[s] = ns[rs1[s]];
          p2[s] = ns[rs2[s]];
          op[s] = ns[rd[s]];
          if (m_need(s)) begin
            pd[s] = pool[k];
            k++;
            ns[rd[s]] = pd[s];
            wn[s] = 1;
          end else begin
            pd[s] = 0;
            wn[s] = 0;
          end
        end
        m_spec  <= ns;
        m_valid <= vl; m_prs1 <= p1; m_prs2 <= p2;
        m_prd   <= pd; m_old  <= op; m_wen  <= wn;
      end else if (out_ready) begin
        m_valid <= '{0, 0};
      end
    end
  end

  always @(negedge clock) begin : compare
    bit f;
    if (model_ok) begin
      f = m_in_ready() && (in0_valid || in1_valid);
      chk("in_ready", in_ready, m_in_ready());
      chk("fl_req0_valid", fl_req0_valid, f && (m_need(0) || m_need(1)));
      chk("fl_req1_valid", fl_req1_valid, f && m_need(0) && m_need(1));
      chk("out0_valid", out0_valid, m_valid[0]);
      chk("out0_prs1", out0_prs1, m_prs1[0]);
      chk("out0_prs2", out0_prs2, m_prs2[0]);
      chk("out0_prd", out0_prd, m_prd[0]);
      chk("out0_old_prd", out0_old_prd, m_old[0]);
      chk("out0_rd_wen", out0_rd_wen, m_wen[0]);
      chk("out1_valid", out1_valid, m_valid[1]);
      chk("out1_prs1", out1_prs1, m_prs1[1]);
      chk("out1_prs2", out1_prs2, m_prs2[1]);
      chk("out1_prd", out1_prd, m_prd[1]);
      chk("out1_old_prd", out1_old_prd, m_old[1]);
      chk("out1_rd_wen", out1_rd_wen, m_wen[1]);
    end
  end

  task automatic idle();
    in0_valid = 0; in0_rs1 = 0; in0_rs2 = 0; in0_rd = 0; in0_rd_wen = 0;
    in1_valid = 0; in1_rs1 = 0; in1_rs2 = 0; in1_rd = 0; in1_rd_wen = 0;
    fl_avail_count = 6'd32; fl_req0_data = 0; fl_req1_data = 0;
    out_ready = 1; flush = 0;
    cmt0_valid = 0; cmt0_rd = 0; cmt0_prd = 0;
    cmt1_valid = 0; cmt1_rd = 0; cmt1_prd = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
    #1;
  endtask

  initial begin
    idle();
    reset = 1;
    tick(); tick();
    settle();
    chk("rst_out0_valid", out0_valid, 0);
    chk("rst_out1_prd", out1_prd, 0);
    chk("rst_fl_req0", fl_req0_valid, 0);
    tick();
    reset = 0;

    // First rename after reset
    in0_valid = 1; in0_rs1 = 1; in0_rs2 = 2; in0_rd = 3; in0_rd_wen = 1;
    settle();
    chk("t1_req0", fl_req0_valid, 1);
    tick(); idle(); settle();
    chk("t1_prs1", out0_prs1, 33);
    chk("t1_prs2", out0_prs2, 34);
    chk("t1_prd", out0_prd, 0);
    chk("t1_old", out0_old_prd, 35);
    chk("t1_wen", out0_rd_wen, 1);

    // Dependent pair inside one group
    tick();
    in0_valid = 1; in0_rd = 5; in0_rd_wen = 1;
    in1_valid = 1; in1_rs1 = 5; in1_rd = 5; in1_rd_wen = 1;
    fl_req0_data = 0; fl_req1_data = 1;
    settle();
    chk("t2_req0", fl_req0_valid, 1);
    chk("t2_req1", fl_req1_valid, 1);
    tick(); idle();
    in0_valid = 1; in0_rs1 = 5;
    settle();
    chk("t2_prs1", out1_prs1, 0);
    chk("t2_prd", out1_prd, 1);
    chk("t2_old", out1_old_prd, 0);
    tick(); idle(); settle();
    chk("t2_lookup", out0_prs1, 1);

    // Only slot 1 allocates
    tick();
    in0_valid = 1; in1_valid = 1; in1_rd = 8; in1_rd_wen = 1; fl_req0_data = 7;
    settle();
    chk("t3_req0", fl_req0_valid, 1);
    chk("t3_req1", fl_req1_valid, 0);
    tick(); idle(); settle();
    chk("t3_prd1", out1_prd, 7);
    chk("t3_prd0", out0_prd, 0);

    // Not enough free pregs for the pair
    tick();
    in0_valid = 1; in0_rd = 10; in0_rd_wen = 1;
    in1_valid = 1; in1_rd = 11; in1_rd_wen = 1;
    fl_req0_data = 20; fl_req1_data = 21; fl_avail_count = 1;
    settle();
    chk("t4_ready_lo", in_ready, 0);
    chk("t4_req_lo", fl_req0_valid, 0);
    tick(); settle();
    chk("t4_ready_lo2", in_ready, 0);
    fl_avail_count = 2;
    #1;
    chk("t4_ready_hi", in_ready, 1);
    tick(); idle(); settle();
    chk("t4_prd0", out0_prd, 20);
    chk("t4_prd1", out1_prd, 21);

    // Backpressure holds the output group
    out_ready = 0;
    in0_valid = 1; in0_rd = 12; in0_rd_wen = 1; fl_req0_data = 30;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("t5_ready_lo", in_ready, 0);
      chk("t5_hold_prd", out0_prd, 20);
      chk("t5_hold_valid", out0_valid, 1);
      tick();
    end
    out_ready = 1;
    settle();
    chk("t5_ready_hi", in_ready, 1);
    tick(); idle(); settle();
    chk("t5_prd", out0_prd, 30);

    // Flush with a same-cycle commit, then flush discarding a rename
    tick();
    in0_valid = 1; in0_rd = 4; in0_rd_wen = 1; fl_req0_data = 9;
    tick(); idle();
    flush = 1; cmt0_valid = 1; cmt0_rd = 4; cmt0_prd = 9;
    in0_valid = 1; in0_rd = 1; in0_rd_wen = 1;
    settle();
    chk("t6_flush_ready", in_ready, 0);
    chk("t6_flush_req", fl_req0_valid, 0);
    tick(); idle(); settle();
    chk("t6_v0_after_flush", out0_valid, 0);
    chk("t6_v1_after_flush", out1_valid, 0);
    in0_valid = 1; in0_rs1 = 4;
    tick(); idle(); settle();
    chk("t6_rs4", out0_prs1, 9);
    in0_valid = 1; in0_rd = 6; in0_rd_wen = 1; fl_req0_data = 10;
    tick(); idle(); flush = 1;
    tick(); idle(); settle();
    chk("t6_v0_flush2", out0_valid, 0);
    in0_valid = 1; in0_rs1 = 6;
    tick(); idle(); settle();
    chk("t6_rs6", out0_prs1, 38);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      tick();
      reset = ($urandom_range(0, 199) == 0);
      in0_valid = $urandom_range(0, 3) != 0; in1_valid = $urandom_range(0, 2) != 0;
      in0_rs1 = 5'($urandom); in0_rs2 = 5'($urandom); in0_rd = 5'($urandom_range(0, 7));
      in1_rs1 = 5'($urandom_range(0, 7)); in1_rs2 = 5'($urandom); in1_rd = 5'($urandom_range(0, 7));
      in0_rd_wen = $urandom_range(0, 3) != 0; in1_rd_wen = $urandom_range(0, 3) != 0;
      fl_avail_count = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 3));
      fl_req0_data = 6'($urandom); fl_req1_data = 6'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      flush = ($urandom_range(0, 15) == 0);
      cmt0_valid = $urandom_range(0, 1); cmt0_rd = 5'($urandom_range(0, 7)); cmt0_prd = 6'($urandom);
      cmt1_valid = $urandom_range(0, 1); cmt1_rd = 5'($urandom_range(0, 7)); cmt1_prd = 6'($urandom);
    end
    tick(); idle(); reset = 0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rename_map_table.md
Name: rename_map_table

Overview:
- Two-wide register rename stage. Sits between decode and dispatch, directly upstream of the physical-register freelist.
- Translates architectural source and destination registers to physical registers using a speculative map table. Pulls new destination pregs from the freelist and reports the displaced preg (old_prd) for later freeing at commit.
- Keeps an architectural map table, updated by commit, that restores the speculative table on flush.

Parameters:
- ARCH_REGS, 32, number of architectural registers
- LOG_ARCH_REGS, 5, index width of architectural registers
- PREG_IDX_WIDTH, 6, physical register index width
- AVAIL_WIDTH, 6, width of the freelist available-count input

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in0_valid / in1_valid  in  1  decode slot valid; slot 1 is younger
- in0_rs1, in0_rs2, in0_rd / in1_*  in  LOG_ARCH_REGS  arch sources and destination
- in0_rd_wen / in1_rd_wen  in  1  slot writes rd
- in_ready  out  1  group accepted this cycle when high
- fl_avail_count  in  AVAIL_WIDTH  free pregs currently in freelist
- fl_req0_valid / fl_req1_valid  out  1  freelist dequeue requests
- fl_req0_data / fl_req1_data  in  PREG_IDX_WIDTH  head and head+1 free pregs
- out0_valid / out1_valid  out  1  renamed slot valid
- out0_prs1, out0_prs2, out0_prd, out0_old_prd / out1_*  out  PREG_IDX_WIDTH  renamed operands
- out0_rd_wen / out1_rd_wen  out  1  slot allocated a new preg
- out_ready  in  1  dispatch accepts the output group
- cmt0_valid / cmt1_valid  in  1  commit update; cmt1 is younger
- cmt0_rd, cmt1_rd  in  LOG_ARCH_REGS  committed arch dest
- cmt0_prd, cmt1_prd  in  PREG_IDX_WIDTH  committed preg
- flush  in  1  squash everything in flight and restore spec table

Behaviour:

Reset:
- Both spec and arch tables map arch i to preg 32+i.
- out*_valid = 0; all out data = 0; fl_req*_valid = 0.
- Reset overrides flush, commit, and fire in the same cycle.

Allocation need:
- needN = inN_valid & inN_rd_wen & (inN_rd != 0).
- nalloc = need0 + need1, a value in 0..2.

Handshake:
- out_free = !out0_valid & !out1_valid | out_ready.
- in_ready = out_free & !flush & (fl_avail_count >= nalloc).
- fire = in_ready & (in0_valid | in1_valid).
- A group is accepted whole or not at all; there is no partial acceptance.

Freelist request mapping (combinational from fire):
- The first slot with need uses port 0; the second uses port 1.
- fl_req0_valid = fire & (need0 | need1).
- fl_req1_valid = fire & need0 & need1.
- newp0 = fl_req0_data.
- newp1 = need0 ? fl_req1_data : fl_req0_data.

Source lookup:
- Sources read the spec table as it stood before this group's updates.
- Slot 1 bypass: if need0 and in1_rsX == in0_rd, then out1_prsX = newp0.
- If need0 and in1_rd == in0_rd, then out1_old_prd = newp0.

Output register (latency 1 cycle):
- On fire, out* load the renamed values; outN_prd = newpN when needN, else 0.
- outN_rd_wen = needN.
- Else if out_ready, out*_valid clear.
- Else out* hold.

Spec table write on fire:
- Slot 0 writes in0_rd -> newp0 when need0.
- Slot 1 writes in1_rd -> newp1 when need1.
- Same rd in both slots: slot 1 value wins.

Arch table write:
- cmtN_valid & cmtN_rd != 0 writes cmtN_rd -> cmtN_prd.
- Same rd in both ports: cmt1 wins.
- Arch-table writes occur every cycle, regardless of flush or fire.

Flush:
- Next cycle out*_valid = 0.
- Spec table = arch table including this cycle's commits.
- in_ready = 0 during the flush cycle; no freelist requests are issued.

Arch reg 0:
- Never remapped; always reads preg 32.

Test Plan:
- After reset, in0 {rs1=1, rs2=2, rd=3, wen}, fl_req0_data=0, avail=32 -> fl_req0_valid=1; next cycle out0 prs1=33, prs2=34, prd=0, old_prd=35, rd_wen=1.
- Dependent pair: in0 rd=5, in1 rs1=5, rd=5, fl data 0/1 -> fl_req0/1_valid=1; out1 prs1=0, prd=1, old_prd=0; a later lookup of rs=5 returns 1.
- Only slot 1 needs a preg (in0 rd_wen=0), fl_req0_data=7 -> fl_req0_valid=1, fl_req1_valid=0; out1_prd=7.
- avail=1 with two allocating slots -> in_ready=0, no fl requests, outputs hold; raise avail to 2 -> group fires.
- Backpressure: out_ready=0 with valid output -> in_ready=0, outputs stable over 3 cycles; out_ready=1 -> new group latched.
- Rename rd=4 -> preg 9 (uncommitted); commit rd=4, preg 9 in the same cycle as flush -> afterwards rs=4 maps to 9; rename rd=6 -> preg 10 without commit, then flush -> rs=6 maps to 38; out valids 0 the cycle after flush.
